// File: rtl/squash_pkg.sv
// Shared types and constants for the two-player court engine.
package squash_pkg;

    typedef enum logic [1:0] {
        SERVE,
        MOVE,
        POINT,
        GAME_OVER
    } state_t;

    localparam int   MODE_SQUASH = 0;
    localparam int   MODE_TENNIS = 1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/ball_tick_gen.sv
// Step timer: pulses once every TICK_DIV enabled cycles.
module ball_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/squash_court_game.sv
// Two-player court engine: serve, rally, faults and scoring on an N-light bar.
module squash_court_game #(
    parameter int NUM_LIGHTS = 16,
    parameter int TICK_DIV   = 25_000_000,
    parameter int SCORE_W    = 2,
    parameter int WIN_SCORE  = 3,
    parameter int MODE       = 0,
    parameter int HIT_WINDOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rightplayer,
    input  logic                  leftplayer,
    output logic [NUM_LIGHTS-1:0] light,
    output logic [SCORE_W-1:0]    rightpscore,
    output logic [SCORE_W-1:0]    leftpscore,
    output logic                  server,
    output logic                  game_over,
    output logic                  winner
);

    import squash_pkg::*;

    localparam int                 PW       = $clog2(NUM_LIGHTS);
    localparam logic [PW-1:0]      LAST_POS = PW'(NUM_LIGHTS - 1);
    localparam logic [PW-1:0]      RWIN     = PW'(NUM_LIGHTS - HIT_WINDOW);
    localparam logic [PW-1:0]      LWIN     = PW'(HIT_WINDOW);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam bit                 TENNIS   = (MODE == MODE_TENNIS);

    state_t              state, state_n;
    logic [PW-1:0]       pos, pos_n;
    logic                dir, dir_n;
    logic                striker, striker_n;
    logic                scorer, scorer_n;
    logic                server_n;
    logic [SCORE_W-1:0]  rscore_n, lscore_n;
    logic [NUM_LIGHTS-1:0] light_n;
    logic                winner_n;

    logic sync_r, sync_l, prev_r, prev_l;
    logic press_r, press_l;
    logic striker_press, server_press;
    logic strk_right, toward, in_win, at_end, won;
    logic hit, score_evt, tick;

    function automatic logic [SCORE_W-1:0] inc_sat(input logic [SCORE_W-1:0] s);
        return (s == WIN) ? s : s + 1'b1;
    endfunction

    function automatic logic [PW-1:0] park(input logic srv);
        return (TENNIS && !srv) ? '0 : LAST_POS;
    endfunction

    assign press_r       = sync_r & ~prev_r;
    assign press_l       = sync_l & ~prev_l;
    assign striker_press = striker ? press_r : press_l;
    assign server_press  = server ? press_r : press_l;

    // In squash both players stand at the right end.
    assign strk_right = TENNIS ? striker : 1'b1;
    assign toward     = strk_right ? (dir == DIR_RIGHT) : (dir == DIR_LEFT);
    assign in_win     = strk_right ? (pos >= RWIN) : (pos < LWIN);
    assign at_end     = strk_right ? (pos == LAST_POS) : (pos == '0);
    assign won        = scorer ? (rightpscore == WIN) : (leftpscore == WIN);

    ball_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .en    ((state == MOVE) || (state == POINT)),
        .clr   (hit || (state_n != state)),
        .tick  (tick)
    );

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        dir_n     = dir;
        striker_n = striker;
        server_n  = server;
        scorer_n  = scorer;
        rscore_n  = rightpscore;
        lscore_n  = leftpscore;
        hit       = 1'b0;
        score_evt = 1'b0;
        unique case (state)
            SERVE: begin
                if (server_press) begin
                    state_n   = MOVE;
                    dir_n     = (TENNIS && !server) ? DIR_RIGHT : DIR_LEFT;
                    striker_n = ~server;
                end
            end
            MOVE: begin
                // A press is judged on the pre-step position and beats a tick.
                if (striker_press) begin
                    if (toward && in_win) begin
                        hit       = 1'b1;
                        dir_n     = ~dir;
                        striker_n = ~striker;
                    end else begin
                        score_evt = 1'b1;
                    end
                end else if (tick) begin
                    if (toward && at_end)
                        score_evt = 1'b1;
                    else if (!TENNIS && dir == DIR_LEFT && pos == '0) begin
                        dir_n = DIR_RIGHT;
                        pos_n = PW'(1);
                    end else if (dir == DIR_RIGHT)
                        pos_n = pos + 1'b1;
                    else
                        pos_n = pos - 1'b1;
                end
            end
            POINT: begin
                if (tick) begin
                    if (won)
                        state_n = GAME_OVER;
                    else begin
                        state_n   = SERVE;
                        server_n  = scorer;
                        pos_n     = park(scorer);
                        dir_n     = (TENNIS && !scorer) ? DIR_RIGHT : DIR_LEFT;
                        striker_n = ~scorer;
                    end
                end
            end
            GAME_OVER: begin
            end
            default: begin
            end
        endcase
        if (score_evt) begin
            state_n  = POINT;
            scorer_n = ~striker;
            if (~striker)
                rscore_n = inc_sat(rightpscore);
            else
                lscore_n = inc_sat(leftpscore);
        end
    end

    always_comb begin
        light_n  = '0;
        winner_n = 1'b0;
        unique case (state_n)
            SERVE, MOVE: light_n[pos_n] = 1'b1;
            POINT:       light_n = '1;
            GAME_OVER: begin
                winner_n = scorer_n;
                for (int i = 0; i < NUM_LIGHTS; i++)
                    light_n[i] = (i >= NUM_LIGHTS / 2) ? scorer_n : ~scorer_n;
            end
            default:     light_n = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SERVE;
            pos         <= LAST_POS;
            dir         <= DIR_LEFT;
            striker     <= 1'b0;
            scorer      <= 1'b0;
            server      <= 1'b1;
            rightpscore <= '0;
            leftpscore  <= '0;
            light       <= {1'b1, {(NUM_LIGHTS-1){1'b0}}};
            game_over   <= 1'b0;
            winner      <= 1'b0;
            sync_r      <= 1'b1;
            sync_l      <= 1'b1;
            prev_r      <= 1'b1;
            prev_l      <= 1'b1;
        end else begin
            state       <= state_n;
            pos         <= pos_n;
            dir         <= dir_n;
            striker     <= striker_n;
            scorer      <= scorer_n;
            server      <= server_n;
            rightpscore <= rscore_n;
            leftpscore  <= lscore_n;
            light       <= light_n;
            game_over   <= (state_n == GAME_OVER);
            winner      <= winner_n;
            sync_r      <= rightplayer;
            sync_l      <= leftplayer;
            prev_r      <= sync_r;
            prev_l      <= sync_l;
        end
    end

endmodule
